// File: rtl/shift_pkg.sv
// Shared types for the serial deserializer: FSM states, shift-register controls,
// and the shift-register next-value function that the top and the register share.
package shift_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SR_HOLD  = 2'b00,
        SR_LEFT  = 2'b01,
        SR_RIGHT = 2'b10,
        SR_LOAD  = 2'b11
    } sr_ctrl_e;

    // Operates on a zero-padded 32-bit container; callers truncate back to their width.
    function automatic logic [31:0] sr_step(input logic [31:0] q, input int w,
                                            input logic sin, input sr_ctrl_e ctrl,
                                            input logic [31:0] ld);
        case (ctrl)
            SR_LEFT:  return {q[30:0], sin};
            SR_RIGHT: return (q >> 1) | ({31'd0, sin} << (w - 1));
            SR_LOAD:  return ld;
            default:  return q;
        endcase
    endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register: ctrl 00 hold, 01 shift left (sin into bit 0),
// 10 shift right (sin into bit W-1), 11 parallel load.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  sr_ctrl_e       ctrl_i,
    input  logic           sin_i,
    input  logic [W-1:0]   load_i,
    output logic [W-1:0]   q_o
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = W'(sr_step(32'(q_q), W, sin_i, ctrl_i, 32'(load_i)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer with valid/ready output and sticky overrun.
// Define DESER_PARITY_EN to append an even-parity bit to each frame and add parity_err.
module serial_deserializer
    import shift_pkg::*;
#(
    parameter int N         = DEFAULT_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sin,
    input  logic         sin_valid,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         busy,
    output logic         overrun
`ifdef DESER_PARITY_EN
    ,
    output logic         parity_err
`endif
);

`ifdef DESER_PARITY_EN
    localparam int FRAME = N + 1;
`else
    localparam int FRAME = N;
`endif
    localparam int CW = $clog2(N + 2);
    localparam logic [CW-1:0] LAST  = CW'(FRAME - 1);
    localparam logic [CW-1:0] NDATA = CW'(N);

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   dout_q;
    logic           dout_valid_q;
    logic           overrun_q;
    logic [N-1:0]   sr_q;
    logic [N-1:0]   word_d;
    sr_ctrl_e       sr_ctrl;
    logic           take, done;

    // start has priority over data in both states: the start-cycle bit is never sampled
    assign take = (state_q == SHIFT) && !start && sin_valid;
    assign done = take && (cnt_q == LAST);

    always_comb begin
        sr_ctrl = SR_HOLD;
        if (start)
            sr_ctrl = SR_LOAD;
        else if (take && (cnt_q < NDATA))
            sr_ctrl = MSB_FIRST ? SR_LEFT : SR_RIGHT;
        // Word as it will stand after this edge; the parity bit cycle holds, so this equals sr_q
        word_d = N'(sr_step(32'(sr_q), N, sin, sr_ctrl, 32'd0));
    end

    univ_shift_reg #(.W(N)) u_sr (
        .clk    (clk),
        .rst_n  (reset),
        .ctrl_i (sr_ctrl),
        .sin_i  (sin),
        .load_i ('0),
        .q_o    (sr_q)
    );

`ifdef DESER_PARITY_EN
    logic parity_err_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef DESER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= SHIFT;
                    cnt_q   <= '0;
                end
                SHIFT: begin
                    if (start) begin
                        cnt_q <= '0;
                    end else if (sin_valid) begin
                        if (done) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (done && (!dout_valid_q || dout_ready)) begin
                dout_q       <= word_d;
                dout_valid_q <= 1'b1;
`ifdef DESER_PARITY_EN
                parity_err_q <= (^word_d) ^ sin;
`endif
            end else if (done) begin
                overrun_q    <= 1'b1;
            end else if (dout_valid_q && dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == SHIFT);
    assign overrun    = overrun_q;
`ifdef DESER_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: an MSB-first and an LSB-first instance share stimulus;
// words are scoreboarded per instance. Honours DESER_PARITY_EN when defined.
module tb_serial_deserializer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset, start, sin, sin_valid, dout_ready;
    logic [N-1:0] dout_m, dout_l;
    logic         dv_m, dv_l, busy_m, busy_l, ov_m, ov_l;
    logic         pe_m, pe_l;

    int checks = 0;
    int errors = 0;

    // {parity_err, dout}
    logic [N:0] q_m[$];
    logic [N:0] q_l[$];

    always #5 clk = ~clk;

`ifndef DESER_PARITY_EN
    assign pe_m = 1'b0;
    assign pe_l = 1'b0;
`endif

    serial_deserializer #(.N(N), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .start(start), .sin(sin), .sin_valid(sin_valid),
        .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
        .busy(busy_m), .overrun(ov_m)
`ifdef DESER_PARITY_EN
        , .parity_err(pe_m)
`endif
    );

    serial_deserializer #(.N(N), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .start(start), .sin(sin), .sin_valid(sin_valid),
        .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
        .busy(busy_l), .overrun(ov_l)
`ifdef DESER_PARITY_EN
        , .parity_err(pe_l)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a word is consumed on an edge where valid and ready are both high
    always @(negedge clk) begin
        if (reset === 1'b1 && dout_ready === 1'b1) begin
            if (dv_m === 1'b1) begin
                if (q_m.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL msb_unexpected_word: got %0h expected none", dout_m);
                end else check("msb_word", {23'd0, pe_m, dout_m}, {23'd0, q_m.pop_front()});
            end
            if (dv_l === 1'b1) begin
                if (q_l.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL lsb_unexpected_word: got %0h expected none", dout_l);
                end else check("lsb_word", {23'd0, pe_l, dout_l}, {23'd0, q_l.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit gap);
        if (gap) step();   // sin_valid low cycle: must be a no-op
        sin = b;
        sin_valid = 1'b1;
        step();
        sin_valid = 1'b0;
        sin = 1'b0;
    endtask

    // A qualified 1 is driven during start; it must not land in the word
    task automatic start_frame();
        start = 1'b1;
        sin = 1'b1;
        sin_valid = 1'b1;
        step();
        start = 1'b0;
        sin_valid = 1'b0;
        sin = 1'b0;
    endtask

    task automatic send_word(input logic [N-1:0] w, input logic [N-1:0] exp_l,
                             input bit push, input logic pbit, input logic perr, input bit gap);
        if (push) begin
`ifdef DESER_PARITY_EN
            q_m.push_back({perr, w});
            q_l.push_back({perr, exp_l});
`else
            q_m.push_back({1'b0, w});
            q_l.push_back({1'b0, exp_l});
`endif
        end
        start_frame();
        for (int i = N - 1; i >= 0; i--) send_bit(w[i], gap && (i % 3 == 1));
`ifdef DESER_PARITY_EN
        send_bit(pbit, 1'b0);
`endif
    endtask

    typedef struct {
        logic [N-1:0] word;
        logic [N-1:0] exp_lsb;
        bit           gap;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 8'h3C, 1'b1};
        vecs[2] = '{8'h0F, 8'hF0, 1'b0};
        vecs[3] = '{8'h01, 8'h80, 1'b1};
        vecs[4] = '{8'h96, 8'h69, 1'b0};
        vecs[5] = '{8'h12, 8'h48, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1};

        reset = 1'b0; start = 1'b0; sin = 1'b0; sin_valid = 1'b0; dout_ready = 1'b1;
        #12;
        check("rst_outputs_m", {20'd0, dout_m, dv_m, busy_m, ov_m, pe_m}, 32'd0);
        check("rst_outputs_l", {20'd0, dout_l, dv_l, busy_l, ov_l, pe_l}, 32'd0);
        step();
        reset = 1'b1;
        step();

        // Latency and busy on the basic A5 frame
        start_frame();
        check("busy_after_start", {30'd0, busy_m, busy_l}, 32'd3);
        q_m.push_back({1'b0, 8'hA5});
        q_l.push_back({1'b0, 8'hA5});
        for (int i = N - 1; i >= 0; i--) send_bit(vecs[0].word[i], 1'b0);
`ifdef DESER_PARITY_EN
        send_bit(1'b0, 1'b0);
`endif
        check("valid_latency1", {30'd0, dv_m, dv_l}, 32'd3);
        check("busy_done", {30'd0, busy_m, busy_l}, 32'd0);
        step();
        check("valid_one_cycle", {30'd0, dv_m, dv_l}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            send_word(vecs[i].word, vecs[i].exp_lsb, 1'b1, ^vecs[i].word, 1'b0, vecs[i].gap);
            step();
        end

        // Overrun: second word dropped while the first is held
        dout_ready = 1'b0;
        send_word(8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        send_word(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("ovr_hold_dout", {24'd0, dout_m}, 32'h3C);
        check("ovr_flag", {30'd0, ov_m, ov_l}, 32'd3);
        check("ovr_valid_held", {30'd0, dv_m, dv_l}, 32'd3);
        dout_ready = 1'b1;
        step();
        check("ovr_drained", {30'd0, dv_m, dv_l}, 32'd0);
        check("ovr_sticky", {30'd0, ov_m, ov_l}, 32'd3);

        // Abort: partial frame of five bits, then a restart
        start_frame();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        check("abort_busy", {30'd0, busy_m, busy_l}, 32'd3);
        check("abort_no_word", {30'd0, dv_m, dv_l}, 32'd0);
        send_word(8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // Reset mid-frame
        start_frame();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midrst_m", {20'd0, dout_m, dv_m, busy_m, ov_m, pe_m}, 32'd0);
        check("midrst_l", {20'd0, dout_l, dv_l, busy_l, ov_l, pe_l}, 32'd0);
        step();
        reset = 1'b1;
        step();
        send_word(8'h81, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst_dout", {24'd0, dout_m}, 32'h81);
        step();
        check("post_rst_ovr_clear", {30'd0, ov_m, ov_l}, 32'd0);

`ifdef DESER_PARITY_EN
        send_word(8'h07, 8'hE0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("par_good", {31'd0, pe_m}, 32'd0);
        step();
        send_word(8'h07, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("par_bad", {31'd0, pe_m}, 32'd1);
        step();
`endif

        step();
        step();
        check("sb_empty_m", q_m.size(), 32'd0);
        check("sb_empty_l", q_l.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter N, default 8: data word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first received bit lands in dout[N-1]; 0 means the first received bit lands in dout[0].
REQ-003 One clock and one reset: clk is the single clock; reset is asynchronous and active-low.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle frame-start strobe.
- sin, in, 1: serial data bit.
- sin_valid, in, 1: sin is qualified this cycle.
- dout, out, N: assembled word.
- dout_valid, out, 1: dout holds an unconsumed word.
- dout_ready, in, 1: the consumer accepts dout this cycle.
- busy, out, 1: a frame is in progress.
- overrun, out, 1: sticky flag; a word was dropped.

Function
REQ-005 The block SHALL implement the FSM states IDLE and SHIFT, with busy=1 exactly in SHIFT.
REQ-006 Transitions:
- IDLE→SHIFT: on start=1; the bit counter clears. A bit presented with sin_valid in the start cycle SHALL be ignored.
- SHIFT: each cycle with sin_valid=1 shifts sin into the shift register and increments the counter.
- MSB_FIRST=1: shift left, sin enters bit 0.
- MSB_FIRST=0: shift right, sin enters bit N-1.
REQ-007 Frame completion: when the final frame bit is sampled (bit N, or the parity bit per REQ-016), the FSM SHALL return to IDLE at that edge.
REQ-008 The word SHALL be presented on dout with dout_valid=1 on the cycle after the edge that sampled the final bit (latency 1).
REQ-009 Handshake: a word is consumed on any edge where dout_valid=1 and dout_ready=1. While dout_valid=1 and dout_ready=0, dout SHALL be held stable.
REQ-010 Completion with dout_valid=0, or with dout_valid=1 and dout_ready=1 in the same cycle: the new word SHALL be loaded and dout_valid SHALL be 1 on the next cycle.
REQ-011 Completion with dout_valid=1 and dout_ready=0: the new word SHALL be dropped, the old dout retained, and overrun set to 1. overrun stays 1 until reset.
REQ-012 start=1 while in SHIFT SHALL abort the partial frame, clear the counter and remain in SHIFT. A partial word is never presented.
REQ-013 sin_valid=0 in SHIFT SHALL hold the shift register and counter unchanged, with no timeout.
REQ-014 The counter SHALL be sized $clog2(N+2) bits and SHALL never wrap within a frame.

Reset
REQ-015 While reset=0, asynchronously: state=IDLE, counter=0, shift register=0, dout=0, dout_valid=0, busy=0, overrun=0. Deassertion SHALL take effect at the next clk edge. A reset mid-frame discards the partial word.

Configuration
REQ-016 With macro DESER_PARITY_EN defined:
- Each frame carries one extra even-parity bit after the N data bits.
- An extra output parity_err (1 bit) is present.
- At frame completion, parity_err is registered together with dout_valid: 1 if the XOR of the data bits and the parity bit is 1.
- parity_err is valid only while dout_valid=1 and resets to 0.
REQ-017 Without DESER_PARITY_EN: frames are exactly N bits, the parity_err port and parity logic are absent, and behaviour otherwise matches REQ-005..015.

Structure
REQ-018 Package shift_pkg SHALL hold the FSM state enum (IDLE, SHIFT) and the default width constant (8).
REQ-019 One sub-module SHALL be used: univ_shift_reg (ctrl 00 hold, 01 shift left, 10 shift right, 11 load) as the data shift register. The FSM and counter drive its ctrl.

Verification
REQ-020 N=8, MSB_FIRST=1, dout_ready=1: start, then bits 1,0,1,0,0,1,0,1 on consecutive cycles → dout=8'hA5 with dout_valid=1 for one cycle, 1 cycle after the last bit.
REQ-021 MSB_FIRST=0, same bit sequence → dout=8'hA5 bit-reversed, i.e. 8'hA5.
REQ-022 dout_ready=0, send frame 8'h3C then a complete frame 8'hFF → dout stays 8'h3C and overrun=1. Then dout_ready=1 → dout_valid=0 after one edge.
REQ-023 Send 5 bits, pulse start, send 8 bits of 8'h0F → dout=8'h0F only; no word is produced from the aborted 5 bits.
REQ-024 Reset asserted after 4 bits, released, then a full frame of 8'h81 → dout=8'h81. All outputs read 0 during reset.
REQ-025 DESER_PARITY_EN: frame 8'h07 with parity bit 1 → parity_err=0. Same frame with parity bit 0 → parity_err=1.
